// File: rtl/data_mem_responder.sv
// Wait-stated single-port data memory slave: one request in flight, held response,
// out-of-range addresses flagged with RspErr and never touch the array.
//
// state | meaning
// IDLE  | ReqReady high, waiting for ReqValid
// WAIT  | request latched, wait counter running down to the access edge
// RESP  | response presented, held until RspReady
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [15:0] ReqAddr,
    input  logic [15:0] ReqWData,
    output logic        ReqReady,
    output logic        RspValid,
    output logic [15:0] RspRData,
    output logic        RspErr,
    input  logic        RspReady,
    output logic [15:0] AccessCount
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          wr_q, wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [15:0]   access_count_q, access_count_d;
    logic          mem_we;
    logic          in_range;
    logic [AW-1:0] mem_idx;

    logic [15:0]   mem_q [DEPTH];

    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign mem_idx  = addr_q[AW-1:0];

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        access_count_d = access_count_q;
        mem_we         = 1'b0;

        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    wr_d       = ReqWrite;
                    addr_d     = ReqAddr;
                    wdata_d    = ReqWData;
                    wait_cnt_d = 4'(WAIT_STATES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    // access edge: the response registers are loaded here and held through RESP
                    state_d = RESP;
                    if (in_range) begin
                        err_d   = 1'b0;
                        rdata_d = wr_q ? 16'h0000 : mem_q[mem_idx];
                        mem_we  = wr_q;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 16'h0000;
                    end
                end
            end
            RESP: begin
                if (RspReady) begin
                    state_d        = IDLE;
                    access_count_d = access_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q        <= IDLE;
            wait_cnt_q     <= 4'd0;
            wr_q           <= 1'b0;
            addr_q         <= 16'h0000;
            wdata_q        <= 16'h0000;
            rdata_q        <= 16'h0000;
            err_q          <= 1'b0;
            access_count_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            access_count_q <= access_count_d;
        end
    end

    // array contents survive reset; only the write strobe is gated
    always_ff @(posedge Clock) begin
        if (ResetN && mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    assign ReqReady    = (state_q == IDLE);
    assign RspValid    = (state_q == RESP);
    assign RspRData    = rdata_q;
    assign RspErr      = err_q;
    assign AccessCount = access_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a wait-stated instance driven with directed and random
// traffic against an array model, plus a zero-wait instance for back-to-back timing.
module tb_data_mem_responder;

    localparam int WS     = 2;
    localparam int DEPTH  = 256;
    localparam int WS0    = 0;
    localparam int DEPTH0 = 16;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        ReqValid, ReqWrite, RspReady;
    logic [15:0] ReqAddr, ReqWData;
    logic        ReqReady, RspValid, RspErr;
    logic [15:0] RspRData, AccessCount;

    logic        b_ReqValid, b_ReqWrite, b_RspReady;
    logic [15:0] b_ReqAddr, b_ReqWData;
    logic        b_ReqReady, b_RspValid, b_RspErr;
    logic [15:0] b_RspRData, b_AccessCount;

    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;

    logic [15:0] model_mem [DEPTH];
    bit          known     [DEPTH];
    logic [15:0] exp_count;
    logic [15:0] b_mem     [DEPTH0];

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
        .Clock(Clock), .ResetN(ResetN), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqReady(ReqReady), .RspValid(RspValid),
        .RspRData(RspRData), .RspErr(RspErr), .RspReady(RspReady), .AccessCount(AccessCount)
    );

    data_mem_responder #(.DEPTH(DEPTH0), .WAIT_STATES(WS0)) u_dut0 (
        .Clock(Clock), .ResetN(ResetN), .ReqValid(b_ReqValid), .ReqWrite(b_ReqWrite),
        .ReqAddr(b_ReqAddr), .ReqWData(b_ReqWData), .ReqReady(b_ReqReady), .RspValid(b_RspValid),
        .RspRData(b_RspRData), .RspErr(b_RspErr), .RspReady(b_RspReady), .AccessCount(b_AccessCount)
    );

    task automatic scramble_req();
        ReqValid = 1'($urandom_range(0, 1));
        ReqWrite = 1'($urandom_range(0, 1));
        ReqAddr  = 16'($urandom);
        ReqWData = 16'($urandom);
    endtask

    // One full transaction on u_dut; hold = number of extra RESP cycles with RspReady low.
    task automatic do_access(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                             input int hold);
        int          i;
        bit          exp_err;
        bit          chk_rd;
        logic [15:0] exp_rd;
        logic [15:0] s_rd;
        logic        s_err;

        i = 0;
        while (ReqReady !== 1'b1 && i < 20) begin
            @(negedge Clock);
            i++;
        end
        n_total++;
        if (ReqReady !== 1'b1) $display("FAIL ready_wait: ReqReady=%b required 1", ReqReady);
        else n_pass++;

        exp_err = (addr >= 16'(DEPTH));
        chk_rd  = 1'b1;
        exp_rd  = 16'h0000;
        if (!exp_err) begin
            if (wr) begin
                model_mem[addr] = wdata;
                known[addr]     = 1'b1;
            end else begin
                exp_rd = model_mem[addr];
                chk_rd = known[addr];
            end
        end

        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqAddr  = addr;
        ReqWData = wdata;
        RspReady = (hold == 0);
        @(posedge Clock);

        for (i = 0; i <= 20; i++) begin
            @(negedge Clock);
            scramble_req();
            if (RspValid === 1'b1) break;
            n_total++;
            if (ReqReady !== 1'b0 || AccessCount !== exp_count)
                $display("FAIL busy: ReqReady=%b AccessCount=%h required 0 %h", ReqReady, AccessCount, exp_count);
            else n_pass++;
            @(posedge Clock);
        end

        n_total++;
        if (i !== WS + 1) $display("FAIL latency: %0d edges required %0d", i, WS + 1);
        else n_pass++;
        n_total++;
        if (RspErr !== exp_err) $display("FAIL rsp_err addr=%h: %b required %b", addr, RspErr, exp_err);
        else n_pass++;
        if (chk_rd) begin
            n_total++;
            if (RspRData !== exp_rd) $display("FAIL rsp_rdata addr=%h: %h required %h", addr, RspRData, exp_rd);
            else n_pass++;
        end

        s_rd  = RspRData;
        s_err = RspErr;
        repeat (hold) begin
            @(posedge Clock);
            @(negedge Clock);
            scramble_req();
            n_total++;
            if (RspValid !== 1'b1 || RspRData !== s_rd || RspErr !== s_err || ReqReady !== 1'b0 ||
                AccessCount !== exp_count)
                $display("FAIL hold_stable: valid=%b rdata=%h err=%b ready=%b cnt=%h required 1 %h %b 0 %h",
                         RspValid, RspRData, RspErr, ReqReady, AccessCount, s_rd, s_err, exp_count);
            else n_pass++;
        end

        RspReady = 1'b1;
        @(posedge Clock);
        exp_count = exp_count + 16'd1;
        @(negedge Clock);
        ReqValid = 1'b0;
        RspReady = 1'b0;
        n_total++;
        if (RspValid !== 1'b0 || ReqReady !== 1'b1 || AccessCount !== exp_count)
            $display("FAIL complete: valid=%b ready=%b cnt=%h required 0 1 %h",
                     RspValid, ReqReady, AccessCount, exp_count);
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if (ReqReady !== 1'b1 || RspValid !== 1'b0 || RspRData !== 16'h0 || RspErr !== 1'b0 ||
            AccessCount !== 16'h0)
            $display("FAIL %s: ready=%b valid=%b rdata=%h err=%b cnt=%h required 1 0 0000 0 0000",
                     tag, ReqReady, RspValid, RspRData, RspErr, AccessCount);
        else n_pass++;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'h0003; ReqWData = 16'h7777;
        b_ReqValid = 1'b1; b_ReqWrite = 1'b1; b_ReqAddr = 16'h0003; b_ReqWData = 16'h7777;
        RspReady = 1'b1; b_RspReady = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_reset_outputs("reset_main");
        n_total++;
        if (b_ReqReady !== 1'b1 || b_RspValid !== 1'b0 || b_RspRData !== 16'h0 || b_RspErr !== 1'b0 ||
            b_AccessCount !== 16'h0)
            $display("FAIL reset_b2b: ready=%b valid=%b rdata=%h err=%b cnt=%h required 1 0 0000 0 0000",
                     b_ReqReady, b_RspValid, b_RspRData, b_RspErr, b_AccessCount);
        else n_pass++;
        ResetN = 1'b1;
        ReqValid = 1'b0; b_ReqValid = 1'b0; RspReady = 1'b0; b_RspReady = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        n_total++;
        if (ReqReady !== 1'b1 || b_ReqReady !== 1'b1)
            $display("FAIL reset_release_ready: %b %b required 1 1", ReqReady, b_ReqReady);
        else n_pass++;
        exp_count = 16'h0;
    endtask

    task automatic test_write_read();
        do_access(1'b1, 16'h0005, 16'h1234, 0);
        do_access(1'b0, 16'h0005, 16'h0000, 0);
        n_total++;
        if (AccessCount !== 16'd2) $display("FAIL write_read_count: %h required 0002", AccessCount);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [15:0] v;
        v = 16'($urandom);
        do_access(1'b1, 16'h0000, v, 0);
        do_access(1'b0, 16'h0100, 16'h0000, 0);
        do_access(1'b1, 16'h0100, 16'hBEEF, 0);
        do_access(1'b0, 16'h0000, 16'h0000, 0);
        do_access(1'b1, 16'h00FF, 16'hC0DE, 0);
        do_access(1'b0, 16'h00FF, 16'h0000, 1);
        do_access(1'b1, 16'hFFFF, 16'h5A5A, 0);
        do_access(1'b0, 16'hFFFF, 16'h0000, 0);
    endtask

    task automatic test_hold();
        do_access(1'b1, 16'h0020, 16'h3C3C, 0);
        do_access(1'b0, 16'h0020, 16'h0000, 5);
        do_access(1'b0, 16'h0200, 16'h0000, 5);
    endtask

    task automatic test_reset_mid_access();
        int i;
        do_access(1'b1, 16'h0010, 16'h5555, 0);
        do_access(1'b0, 16'h0010, 16'h0000, 0);

        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'h0010; ReqWData = 16'hAAAA;
        @(posedge Clock);
        @(negedge Clock);
        ReqValid = 1'b0;
        n_total++;
        if (ReqReady !== 1'b0) $display("FAIL wait_entered: ReqReady=%b required 0", ReqReady);
        else n_pass++;
        ResetN = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        check_reset_outputs("reset_in_wait");
        exp_count = 16'h0;
        repeat (WS + 3) begin
            @(posedge Clock);
            @(negedge Clock);
            n_total++;
            if (RspValid !== 1'b0) $display("FAIL no_rsp_after_reset: RspValid=%b required 0", RspValid);
            else n_pass++;
        end
        do_access(1'b0, 16'h0010, 16'h0000, 0);

        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'h0010; RspReady = 1'b0;
        @(posedge Clock);
        i = 0;
        do begin
            @(negedge Clock);
            ReqValid = 1'b0;
            i++;
            if (RspValid !== 1'b1) @(posedge Clock);
        end while (RspValid !== 1'b1 && i < 20);
        n_total++;
        if (RspValid !== 1'b1 || RspRData !== 16'h5555)
            $display("FAIL pre_reset_resp: valid=%b rdata=%h required 1 5555", RspValid, RspRData);
        else n_pass++;
        RspReady = 1'b1;
        ResetN = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        RspReady = 1'b0;
        check_reset_outputs("reset_in_resp");
        exp_count = 16'h0;
    endtask

    task automatic test_random();
        bit          wr;
        logic [15:0] addr;
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(DEPTH, 65535))
                                               : 16'($urandom_range(0, 15));
            do_access(wr, addr, 16'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_count_wrap();
        @(negedge Clock);
        force u_dut.access_count_q = 16'hFFFF;
        @(posedge Clock);
        @(negedge Clock);
        release u_dut.access_count_q;
        @(posedge Clock);
        @(negedge Clock);
        n_total++;
        if (AccessCount !== 16'hFFFF) $display("FAIL count_preload: %h required ffff", AccessCount);
        else n_pass++;
        exp_count = 16'hFFFF;
        do_access(1'b0, 16'h0005, 16'h0000, 0);
        n_total++;
        if (AccessCount !== 16'h0000) $display("FAIL count_wrap: %h required 0000", AccessCount);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit          op_wr   [9];
        logic [15:0] op_addr [9];
        logic [15:0] op_data [9];
        logic [15:0] exp_rd;
        int          t_acc, t_prev, i;

        for (int n = 0; n < 4; n++) begin
            op_wr[n]   = 1'b1;
            op_addr[n] = 16'(n * 4 + int'($urandom_range(0, 3)));
            op_data[n] = 16'($urandom);
            op_wr[n+4]   = 1'b0;
            op_addr[n+4] = op_addr[n];
            op_data[n+4] = 16'h0;
        end
        op_wr[8] = 1'b0; op_addr[8] = 16'(DEPTH0); op_data[8] = 16'h0;

        b_RspReady = 1'b1;
        i = 0;
        while (b_ReqReady !== 1'b1 && i < 20) begin
            @(negedge Clock);
            i++;
        end
        t_prev = 0;
        for (int n = 0; n < 9; n++) begin
            b_ReqValid = 1'b1;
            b_ReqWrite = op_wr[n];
            b_ReqAddr  = op_addr[n];
            b_ReqWData = op_data[n];
            exp_rd = 16'h0;
            if (op_addr[n] < 16'(DEPTH0)) begin
                if (op_wr[n]) b_mem[op_addr[n]] = op_data[n];
                else exp_rd = b_mem[op_addr[n]];
            end
            @(posedge Clock);
            @(negedge Clock);
            t_acc = cyc;
            n_total++;
            if (b_RspValid !== 1'b0 || b_ReqReady !== 1'b0)
                $display("FAIL b2b_accept op%0d: valid=%b ready=%b required 0 0", n, b_RspValid, b_ReqReady);
            else n_pass++;
            if (n > 0) begin
                n_total++;
                if (t_acc - t_prev !== 3) $display("FAIL b2b_spacing op%0d: %0d edges required 3", n, t_acc - t_prev);
                else n_pass++;
            end
            t_prev = t_acc;
            @(posedge Clock);
            @(negedge Clock);
            n_total++;
            if (b_RspValid !== 1'b1 || b_RspRData !== exp_rd || b_RspErr !== (op_addr[n] >= 16'(DEPTH0)))
                $display("FAIL b2b_rsp op%0d: valid=%b rdata=%h err=%b required 1 %h %b", n, b_RspValid,
                         b_RspRData, b_RspErr, exp_rd, op_addr[n] >= 16'(DEPTH0));
            else n_pass++;
            @(posedge Clock);
            @(negedge Clock);
        end
        b_ReqValid = 1'b0;
        b_RspReady = 1'b0;
        n_total++;
        if (b_AccessCount !== 16'd9) $display("FAIL b2b_count: %h required 0009", b_AccessCount);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        ResetN = 1'b0;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = 16'h0; ReqWData = 16'h0; RspReady = 1'b0;
        b_ReqValid = 1'b0; b_ReqWrite = 1'b0; b_ReqAddr = 16'h0; b_ReqWData = 16'h0; b_RspReady = 1'b0;
        exp_count = 16'h0;
        @(negedge Clock);
        test_reset();
        test_back_to_back();
        test_write_read();
        test_out_of_range();
        test_hold();
        test_reset_mid_access();
        test_random();
        test_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256: number of 16-bit words, valid range 2..65536.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2: extra access latency in cycles, valid range 0..15.
REQ-003 The block SHALL have port Clock, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port ResetN, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port ReqValid, input, 1 bit: CPU request present.
REQ-006 The block SHALL have port ReqWrite, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port ReqAddr, input, 16 bits: word address.
REQ-008 The block SHALL have port ReqWData, input, 16 bits: write data.
REQ-009 The block SHALL have port ReqReady, output, 1 bit: responder can accept a request.
REQ-010 The block SHALL have port RspValid, output, 1 bit: response available.
REQ-011 The block SHALL have port RspRData, output, 16 bits: read data.
REQ-012 The block SHALL have port RspErr, output, 1 bit: address out of range.
REQ-013 The block SHALL have port RspReady, input, 1 bit: CPU consumes the response.
REQ-014 The block SHALL have port AccessCount, output, 16 bits: completed responses.

Function
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP, with reset state IDLE.
REQ-016 ReqReady SHALL be 1 if and only if the state is IDLE.
REQ-017 A request SHALL be accepted at edge k when ResetN=1, ReqValid=1 and ReqReady=1; at that edge the block SHALL latch ReqWrite, ReqAddr and ReqWData, load the wait counter with WAIT_STATES and move to WAIT.
REQ-018 In WAIT, the counter SHALL decrement on each edge while it is nonzero; at the edge where the counter is 0, the block SHALL perform the access and move to RESP.
REQ-019 RspValid SHALL first be 1 after edge k+WAIT_STATES+1, so with WAIT_STATES=0 it is 1 after edge k+1.
REQ-020 In-range write (latched address < DEPTH): the memory word SHALL be updated at the access edge, with RspRData=0 and RspErr=0.
REQ-021 In-range read: RspRData SHALL be set to the memory word at the access edge, with RspErr=0.
REQ-022 Out-of-range access (latched address >= DEPTH): memory SHALL NOT be modified, RspRData SHALL be 0 and RspErr SHALL be 1.
REQ-023 In RESP, RspValid, RspRData and RspErr SHALL be held stable until an edge with RspReady=1.
REQ-024 At the edge in RESP with RspReady=1, the block SHALL move to IDLE and increment AccessCount modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-025 RspValid SHALL be 0 in IDLE and WAIT.
REQ-026 RspRData and RspErr SHALL hold their last values outside RESP; they are don't-care when RspValid=0.
REQ-027 Changes on ReqValid or on any request field after acceptance SHALL have no effect until the block returns to IDLE.
REQ-028 Minimum spacing between accepted requests SHALL be WAIT_STATES+3 edges.
REQ-029 A read issued after a completed write to the same address SHALL return the written data.
REQ-030 RspReady held at 1 while the state is not RESP SHALL be ignored.

Reset
REQ-031 An edge with ResetN=0 SHALL force state=IDLE, RspValid=0, RspRData=0, RspErr=0, AccessCount=0 and wait counter=0; reset SHALL dominate all other inputs.
REQ-032 A request presented at an edge with ResetN=0 SHALL NOT be accepted.
REQ-033 If reset occurs in WAIT before the access edge, the pending write SHALL NOT be performed.
REQ-034 If reset occurs in RESP, the response SHALL be dropped and AccessCount SHALL NOT increment.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 After reset release, ReqReady SHALL be 1.

Verification
REQ-037 Scenario (WAIT_STATES=2): write 0x1234 to address 0x0005 with RspReady tied to 1 -> RspValid is high exactly on the cycle after edge k+3 with RspErr=0; then read 0x0005 -> RspRData=0x1234; AccessCount=2.
REQ-038 Scenario (WAIT_STATES=0): back-to-back reads with RspReady=1 -> each RspValid appears 1 cycle after acceptance; accepts are 3 edges apart.
REQ-039 Scenario (DEPTH=256): read address 0x0100 -> RspErr=1, RspRData=0; then write 0xBEEF to 0x0100 and read address 0x0000 -> unchanged prior value.
REQ-040 Scenario: hold RspReady=0 for 5 cycles in RESP -> RspValid, RspRData and RspErr stay stable and ReqReady=0; raising RspReady -> IDLE on the next edge.
REQ-041 Scenario: write 0xAAAA to 0x0010, then assert ResetN=0 for one edge during WAIT -> outputs reset, AccessCount=0; read 0x0010 returns the old contents, not 0xAAAA.
REQ-042 Scenario: preload AccessCount to 0xFFFF via 65535 completed accesses, or a forced value, then complete one access -> AccessCount=0x0000.
